// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader: state encodings and
// default widths for the memory write port.
package prog_loader_pkg;

   localparam int LDR_ADDR_WIDTH = 16;
   localparam int LDR_REG_WIDTH  = 8;

   typedef enum logic [2:0] {
      LDR_IDLE   = 3'd0,
      LDR_LOAD   = 3'd1,
      LDR_VERIFY = 3'd2,
      LDR_CHECK  = 3'd3,
      LDR_FINISH = 3'd4
   } ldr_state_t;

endpackage

// File: rtl/prog_loader_checksum.sv
// Clearable, enabled modulo-2^REG_WIDTH additive accumulator used for both the
// written-image and read-back checksums.
module ldr_checksum
   import prog_loader_pkg::*;
#(
   parameter int REG_WIDTH = LDR_REG_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clr,
   input  logic                 en,
   input  logic [REG_WIDTH-1:0] din,
   output logic [REG_WIDTH-1:0] sum
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum <= '0;
      end else if (clr) begin
         sum <= '0;
      end else if (en) begin
         sum <= sum + din;
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Boot-time loader: writes a handshaked byte stream to consecutive addresses,
// optionally reads it back to verify a checksum, then hands the bus to fetch.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = LDR_ADDR_WIDTH,
   parameter int REG_WIDTH  = LDR_REG_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH-1:0] length,
   input  logic                  verify_en,
   input  logic                  s_valid,
   input  logic [REG_WIDTH-1:0]  s_data,
   output logic                  s_ready,
   output logic                  mem_owner,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [REG_WIDTH-1:0]  mem_din,
   input  logic [REG_WIDTH-1:0]  mem_dout,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [REG_WIDTH-1:0]  sum_exp,
   output logic [REG_WIDTH-1:0]  sum_act,
   output logic                  trigger_program
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

   ldr_state_t state, state_nxt;

   logic [ADDR_WIDTH-1:0] base_q;
   logic [ADDR_WIDTH-1:0] len_q;
   logic                  verify_q;
   logic [ADDR_WIDTH-1:0] count;
   logic [ADDR_WIDTH-1:0] rcount;
   logic                  rd_vld_p0;
   logic                  rd_vld_p1;

   logic                  start_ok;
   logic                  accept;
   logic                  last_byte;
   logic                  rd_issue;
   logic                  rd_last;
   logic                  chk_fail;

   assign s_ready = (state == LDR_LOAD);

   always_comb begin
      state_nxt = state;
      start_ok  = 1'b0;
      accept    = 1'b0;
      last_byte = 1'b0;
      rd_issue  = 1'b0;
      rd_last   = 1'b0;
      chk_fail  = 1'b0;
      case (state)
         LDR_IDLE: begin
            if (start) begin
               start_ok  = 1'b1;
               state_nxt = (length == '0) ? LDR_FINISH : LDR_LOAD;
            end
         end
         LDR_LOAD: begin
            accept    = s_valid;
            last_byte = s_valid && ((count + ADDR_ONE) == len_q);
            if (last_byte) begin
               state_nxt = verify_q ? LDR_VERIFY : LDR_FINISH;
            end
         end
         LDR_VERIFY: begin
            rd_issue = (rcount != len_q);
            // Reads are issued back to back, so the final capture is the one
            // with no further read in flight behind it.
            rd_last  = rd_vld_p1 && !rd_vld_p0;
            if (rd_last) begin
               state_nxt = LDR_CHECK;
            end
         end
         LDR_CHECK: begin
            chk_fail  = (sum_act != sum_exp);
            state_nxt = chk_fail ? LDR_IDLE : LDR_FINISH;
         end
         LDR_FINISH: begin
            state_nxt = LDR_IDLE;
         end
         default: begin
            state_nxt = LDR_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= LDR_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base_q          <= '0;
         len_q           <= '0;
         verify_q        <= 1'b0;
         count           <= '0;
         rcount          <= '0;
         rd_vld_p0       <= 1'b0;
         rd_vld_p1       <= 1'b0;
         mem_owner       <= 1'b0;
         mem_we          <= 1'b0;
         mem_addr        <= '0;
         mem_din         <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         error           <= 1'b0;
         trigger_program <= 1'b0;
      end else begin
         trigger_program <= 1'b0;
         mem_we          <= 1'b0;
         busy            <= (state_nxt != LDR_IDLE);
         // read address out (p0), read data back from memory (p1)
         rd_vld_p0       <= rd_issue;
         rd_vld_p1       <= rd_vld_p0;
         if (start_ok) begin
            base_q    <= base_addr;
            len_q     <= length;
            verify_q  <= verify_en;
            count     <= '0;
            rcount    <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            mem_owner <= (length != '0);
         end
         if (accept) begin
            mem_we   <= 1'b1;
            mem_addr <= base_q + count;
            mem_din  <= s_data;
            count    <= count + ADDR_ONE;
         end
         if (rd_issue) begin
            mem_addr <= base_q + rcount;
            rcount   <= rcount + ADDR_ONE;
         end
         if (chk_fail) begin
            error     <= 1'b1;
            mem_owner <= 1'b0;
         end
         if (state == LDR_FINISH) begin
            trigger_program <= 1'b1;
            done            <= 1'b1;
            mem_owner       <= 1'b0;
         end
      end
   end

   ldr_checksum #(.REG_WIDTH(REG_WIDTH)) u_sum_exp (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (start_ok),
      .en      (accept),
      .din     (s_data),
      .sum     (sum_exp)
   );

   ldr_checksum #(.REG_WIDTH(REG_WIDTH)) u_sum_act (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (start_ok),
      .en      (rd_vld_p1),
      .din     (mem_dout),
      .sum     (sum_act)
   );

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of load scenarios plus hand-written
// reset, idle-stream and start-while-busy sequences against a memory model.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [15:0] base_addr;
   logic [15:0] length;
   logic        verify_en;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_ready;
   logic        mem_owner;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic        busy;
   logic        done;
   logic        error;
   logic [7:0]  sum_exp;
   logic [7:0]  sum_act;
   logic        trigger_program;

   always #5 clk = ~clk;

   prog_loader #(.ADDR_WIDTH(16), .REG_WIDTH(8)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .start           (start),
      .base_addr       (base_addr),
      .length          (length),
      .verify_en       (verify_en),
      .s_valid         (s_valid),
      .s_data          (s_data),
      .s_ready         (s_ready),
      .mem_owner       (mem_owner),
      .mem_we          (mem_we),
      .mem_addr        (mem_addr),
      .mem_din         (mem_din),
      .mem_dout        (mem_dout),
      .busy            (busy),
      .done            (done),
      .error           (error),
      .sum_exp         (sum_exp),
      .sum_act         (sum_act),
      .trigger_program (trigger_program)
   );

   int checks   = 0;
   int failures = 0;

   // Synchronous-read memory; optional corruption of address 0x0012 on read.
   logic [7:0] mem [0:65535];
   logic       corrupt = 1'b0;
   always @(posedge clk) begin
      if (mem_owner && mem_we) mem[mem_addr] <= mem_din;
      mem_dout <= (corrupt && mem_addr == 16'h0012) ? 8'h84 : mem[mem_addr];
   end

   int unsigned edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   int unsigned start_edge = 32'hFFFF_0000;
   int unsigned trig_edge  = 0;
   int          trig_cnt   = 0;
   int          we_no_owner = 0;
   logic [15:0] wr_mask = '0;
   logic [15:0] wr_addr [$];
   logic [7:0]  wr_data [$];

   always @(negedge clk) begin
      int unsigned rel;
      if (trigger_program) begin
         trig_cnt++;
         trig_edge = edge_cnt;
      end
      if (mem_we) begin
         wr_addr.push_back(mem_addr);
         wr_data.push_back(mem_din);
         if (!mem_owner) we_no_owner++;
         rel = edge_cnt - start_edge;
         if (rel < 16) wr_mask[rel[3:0]] = 1'b1;
      end
   end

   typedef struct {
      logic [15:0] base;
      logic [15:0] len;
      logic        ver;
      logic [7:0]  pat;
      logic [31:0] d;
      logic        corrupt;
      logic        busy_start;
      logic [7:0]  e_sexp;
      logic [7:0]  e_sact;
      logic        e_done;
      logic        e_err;
      int          e_trig;
      int          e_lat;
      logic [15:0] e_mask;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      wr_mask     = '0;
      trig_cnt    = 0;
      we_no_owner = 0;
      start_edge  = 32'hFFFF_0000;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int   k;
      int   p;
      logic hs;
      corrupt = v.corrupt;
      clear_log();
      @(negedge clk);
      base_addr = v.base;
      length    = v.len;
      verify_en = v.ver;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start_edge = edge_cnt;
      start      = 1'b0;
      k = 0;
      p = 0;
      for (int c = 0; c < 40 && k < int'(v.len); c++) begin
         @(negedge clk);
         s_valid = (p < 8) ? v.pat[p] : 1'b1;
         p++;
         s_data = v.d[8*k +: 8];
         if (v.busy_start && c == 1) begin
            start     = 1'b1;
            base_addr = 16'h0070;
            length    = 16'd2;
         end
         hs = s_valid && s_ready;
         @(posedge clk);
         #1;
         start = 1'b0;
         if (hs) k++;
      end
      @(negedge clk);
      s_valid = 1'b0;
      chk($sformatf("v%0d bytes_accepted", idx), k, v.len);
      for (int c = 0; c < 100 && busy; c++) @(negedge clk);
      chk($sformatf("v%0d busy_timeout", idx), busy, 1'b0);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d done", idx), done, v.e_done);
      chk($sformatf("v%0d error", idx), error, v.e_err);
      chk($sformatf("v%0d sum_exp", idx), sum_exp, v.e_sexp);
      chk($sformatf("v%0d sum_act", idx), sum_act, v.e_sact);
      chk($sformatf("v%0d mem_owner", idx), mem_owner, 1'b0);
      chk($sformatf("v%0d trig_count", idx), trig_cnt, v.e_trig);
      if (v.e_trig > 0) chk($sformatf("v%0d trig_latency", idx), trig_edge - start_edge, v.e_lat);
      chk($sformatf("v%0d write_cycles", idx), wr_mask, v.e_mask);
      chk($sformatf("v%0d write_count", idx), wr_addr.size(), v.len);
      chk($sformatf("v%0d we_without_owner", idx), we_no_owner, 0);
      for (int i = 0; i < wr_addr.size() && i < 4; i++) begin
         chk($sformatf("v%0d wr_addr%0d", idx, i), wr_addr[i], 16'(v.base + 16'(i)));
         chk($sformatf("v%0d wr_data%0d", idx, i), wr_data[i], v.d[8*i +: 8]);
      end
      corrupt = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //            base      len    ver  pat    data          cor  bsy  sexp   sact   dn   er   trg lat mask
      vecs[0] = '{16'h0010, 16'd4, 1'b1, 8'hFF, 32'h028504A9, 1'b0, 1'b0, 8'h34, 8'h34, 1'b1, 1'b0, 1, 12, 16'h001E};
      vecs[1] = '{16'h0020, 16'd4, 1'b0, 8'h59, 32'h44332211, 1'b0, 1'b0, 8'hAA, 8'h00, 1'b1, 1'b0, 1,  8, 16'h00B2};
      vecs[2] = '{16'h0010, 16'd4, 1'b1, 8'hFF, 32'h028504A9, 1'b1, 1'b0, 8'h34, 8'h33, 1'b0, 1'b1, 0,  0, 16'h001E};
      vecs[3] = '{16'h0030, 16'd0, 1'b1, 8'hFF, 32'h00000000, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1,  1, 16'h0000};
      vecs[4] = '{16'hFFFE, 16'd4, 1'b1, 8'hFF, 32'hFC030201, 1'b0, 1'b0, 8'h02, 8'h02, 1'b1, 1'b0, 1, 12, 16'h001E};
      vecs[5] = '{16'h0040, 16'd1, 1'b0, 8'hFF, 32'h0000005A, 1'b0, 1'b0, 8'h5A, 8'h00, 1'b1, 1'b0, 1,  2, 16'h0002};
      vecs[6] = '{16'h0010, 16'd4, 1'b0, 8'hFF, 32'h04030201, 1'b0, 1'b1, 8'h0A, 8'h00, 1'b1, 1'b0, 1,  5, 16'h001E};

      reset_n   = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      length    = '0;
      verify_en = 1'b0;
      s_valid   = 1'b0;
      s_data    = '0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {s_ready, mem_owner, mem_we, mem_addr, mem_din, busy, done, error,
                            sum_exp, sum_act, trigger_program}, 64'd0);
      reset_n = 1'b1;

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // Stream valid while idle must not be consumed.
      clear_log();
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 8'hEE;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("idle_s_ready", s_ready, 1'b0);
      end
      s_valid = 1'b0;
      chk("idle_no_write", wr_addr.size(), 0);
      chk("idle_busy", busy, 1'b0);

      // Reset in the middle of a load after two bytes.
      @(negedge clk);
      base_addr = 16'h0050;
      length    = 16'd4;
      verify_en = 1'b0;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 8'h77;
      repeat (2) @(negedge clk);
      chk("midload_sum_exp", sum_exp, 8'hEE);
      chk("midload_busy", busy, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_reset_outputs", {s_ready, mem_owner, mem_we, mem_addr, mem_din, busy, done, error,
                                  sum_exp, sum_act, trigger_program}, 64'd0);
      s_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;

      // Restart from scratch, with an ignored start pulse while busy.
      run_vec(vecs[6], 6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
